// File: rtl/sensor_scan_ctrl.sv
// Sequencer for a 4:1 sensor mux: select, settle, sample, debounce, publish status/change.
// Optional per-channel masking is compiled in with `define SENSOR_SCAN_CH_MASK_EN.
module sensor_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mux_out,
`ifdef SENSOR_SCAN_CH_MASK_EN
  input  logic [3:0] ch_mask,
`endif
  output logic [1:0] mux_sel,
  output logic [3:0] status,
  output logic [3:0] change,
  output logic       scan_done,
  output logic       busy
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = CW'(DEBOUNCE_COUNT);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADVANCE} state_t;

  state_t        state;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] cnt [4];
  logic [CW-1:0] cnt_inc_c;
  logic          masked_c;

  // Count a differing sample on the channel currently selected; never exceeds CNT_MAX.
  assign cnt_inc_c = cnt[mux_sel] + CW'(1);

`ifdef SENSOR_SCAN_CH_MASK_EN
  assign masked_c = ch_mask[mux_sel];
`else
  assign masked_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      mux_sel    <= 2'd0;
      status     <= 4'd0;
      change     <= 4'd0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      change    <= 4'd0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          mux_sel <= 2'd0;
          if (enable) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
          else                           settle_cnt <= settle_cnt + SW'(1);
        end
        SAMPLE: begin
          state     <= ADVANCE;
          scan_done <= (mux_sel == 2'd3);
          // Masked channels are forced low; a pending change is reported once.
          if (masked_c) begin
            status[mux_sel] <= 1'b0;
            cnt[mux_sel]    <= '0;
            change[mux_sel] <= status[mux_sel];
          end else if (mux_out != status[mux_sel]) begin
            if (cnt_inc_c == CNT_MAX) begin
              status[mux_sel] <= mux_out;
              change[mux_sel] <= 1'b1;
              cnt[mux_sel]    <= '0;
            end else begin
              cnt[mux_sel] <= cnt_inc_c;
            end
          end else begin
            cnt[mux_sel] <= '0;
          end
        end
        ADVANCE: begin
          if (enable) begin
            mux_sel    <= mux_sel + 2'd1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            mux_sel <= 2'd0;
            busy    <= 1'b0;
            state   <= IDLE;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed self-checking bench for sensor_scan_ctrl at default parameters.
// The mask scenario runs only when SENSOR_SCAN_CH_MASK_EN is defined.
module tb_sensor_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       mux_out;
  logic [3:0] sensors;
  logic [1:0] mux_sel;
  logic [3:0] status;
  logic [3:0] change;
  logic       scan_done;
  logic       busy;
`ifdef SENSOR_SCAN_CH_MASK_EN
  logic [3:0] ch_mask;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural 4:1 mux feeding the DUT
  assign mux_out = sensors[mux_sel];

  sensor_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mux_out   (mux_out),
`ifdef SENSOR_SCAN_CH_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .mux_sel   (mux_sel),
    .status    (status),
    .change    (change),
    .scan_done (scan_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Run n cycles checking status/change; status flips st0->st1 at cycle flip_at (0 = never).
  task automatic run_window(input int n, input int flip_at, input logic [3:0] st0,
                            input logic [3:0] st1, input logic [3:0] chg);
    for (int i = 1; i <= n; i++) begin
      step();
      check("status", 32'(status), 32'((flip_at != 0 && i >= flip_at) ? st1 : st0));
      check("change", 32'(change), 32'((i == flip_at) ? chg : 4'b0000));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mux_sel"},   32'(mux_sel),   32'd0);
    check({tag, "_status"},    32'(status),    32'd0);
    check({tag, "_change"},    32'(change),    32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    sensors = 4'b0000;
`ifdef SENSOR_SCAN_CH_MASK_EN
    ch_mask = 4'b0000;
`endif
    #12;
    check_reset_outputs("por");

    // Idle scan: select walks 0..3, 6 cycles each, scan_done every 24 cycles
    rst_n  = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k == 1) check("busy_start", 32'(busy), 32'd1);
      check("mux_sel_walk", 32'(mux_sel), 32'(((k - 1) / 6) % 4));
      check("scan_done", 32'(scan_done), 32'((k % 24) == 0));
      check("change_idle", 32'(change), 32'd0);
    end
    check("status_idle", 32'(status), 32'd0);

    // Debounce: ch2 high flips on the 3rd scan, in ch2 ADVANCE (offset 18 of that scan)
    sensors = 4'b0100;
    run_window(72, 66, 4'b0000, 4'b0100, 4'b0100);

    // Glitch reject: ch1 high for 2 scans then low
    sensors = 4'b0110;
    run_window(48, 0, 4'b0100, 4'b0100, 4'b0000);
    sensors = 4'b0100;
    run_window(24, 0, 4'b0100, 4'b0100, 4'b0000);
    // Counter was cleared: a fresh sustained high needs the full 3 scans
    sensors = 4'b0110;
    run_window(72, 60, 4'b0100, 4'b0110, 4'b0010);

    // Disable during ch1 SETTLE: ch1 finishes, then IDLE
    sensors = 4'b0100;
    for (int i = 0; i < 8; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dis_mux_sel_held", 32'(mux_sel), 32'd1);
      check("dis_busy_held", 32'(busy), 32'd1);
    end
    step();
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_mux_sel", 32'(mux_sel), 32'd0);
    check("dis_status", 32'(status), 32'b0110);
    for (int i = 0; i < 3; i++) step();
    check("idle_busy", 32'(busy), 32'd0);
    // Re-enable restarts at ch0 with cleared counters: ch1 low flips on the 3rd scan
    enable = 1'b1;
    run_window(72, 60, 4'b0110, 4'b0100, 4'b0010);

    // Drive all channels high, then reset asynchronously mid-SETTLE
    sensors = 4'b1111;
    for (int i = 0; i < 72; i++) step();
    check("all_high_status", 32'(status), 32'b1111);
    check("all_high_done", 32'(scan_done), 32'd1);
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #2;
    enable = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_status", 32'(status), 32'd0);

`ifdef SENSOR_SCAN_CH_MASK_EN
    // Mask: ch3 set high, then masked -> forced low with one change pulse
    sensors = 4'b1000;
    enable  = 1'b1;
    run_window(72, 72, 4'b0000, 4'b1000, 4'b1000);
    ch_mask = 4'b1000;
    run_window(24, 24, 4'b1000, 4'b0000, 4'b1000);
    run_window(48, 0, 4'b0000, 4'b0000, 4'b0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
